fifo_access_ctrl: RTL and testbench
===================================

# fifo_access_ctrl

Access controller for the push/pop FIFO counter datapath. It arbitrates two producer requesters round-robin for the single push slot and serves one consumer requester for pop. It guards against overflow and underflow using its own occupancy count, and sequences a flush that drains the FIFO to empty. It sits between the requesters and the FIFO, driving the FIFO's `push`/`pop` pins and reporting `fifo_count`.

## Interface
- `MAXCOUNT`, default 16: FIFO depth in entries; must be at least 2.
- `CW`, default `$clog2(MAXCOUNT+1)`: count width.
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_push` in 2: push request per producer; level-sensitive, held until granted.
- `req_pop` in 1: pop request from the consumer; level-sensitive.
- `flush_req` in 1: single-cycle pulse that starts a flush.
- `push` out 1: push strobe to the FIFO; registered.
- `pop` out 1: pop strobe to the FIFO; registered.
- `gnt_push` out 2: one-hot push grant; registered; coincides with `push`.
- `gnt_pop` out 1: pop grant to the consumer; registered; low during flush.
- `fifo_count` out CW: occupancy including the operations issued this cycle.
- `full` out 1: high when `fifo_count == MAXCOUNT`.
- `empty` out 1: high when `fifo_count == 0`.
- `flush_done` out 1: one-cycle pulse when a flush completes.

## Operation
- **States:** RUN and FLUSH.
- **Reset values:** state RUN; `push`, `pop`, `gnt_push`, `gnt_pop` and `flush_done` all 0; `fifo_count` 0; `empty` 1; `full` 0; round-robin pointer `last` = 1, so requester 0 wins first.
- **RUN, pop decision:** `pop_ok = req_pop && fifo_count != 0`.
- **RUN, push decision:** `push_ok = |req_push && (fifo_count < MAXCOUNT || pop_ok)`. A push at full is allowed only when a pop is issued on the same edge.
- **Arbitration:**
  - One requester active: that requester is granted.
  - Both active: the requester other than `last` is granted.
  - `last` updates only when a grant is issued.
- **Count update:** `fifo_count += push_ok - pop_ok`. Simultaneous push and pop leaves the count unchanged. The count never exceeds `MAXCOUNT` and never wraps below 0.
- **Entering FLUSH:** `flush_req` in RUN moves to FLUSH on the next edge. Any push or pop decided on that same edge is still issued.
- **FLUSH:**
  - `push` and `gnt_push` are forced to 0; requests are held off.
  - `pop` is 1 on every edge while `fifo_count != 0`, independent of `req_pop`.
  - `gnt_pop` is 0.
  - When `fifo_count` is 0 at an edge, `flush_done` pulses for one cycle and the state returns to RUN.
- **Flush from empty:** `flush_req` with `fifo_count == 0` produces `flush_done` exactly 2 edges after `flush_req` is sampled (one edge to enter FLUSH, one to exit).
- **Flush ignored:** `flush_req` arriving while already in FLUSH has no effect.
- **Reset mid-operation:** all state, the count and the pointer clear immediately and asynchronously. The controller assumes the FIFO is reset by the same `rst`.

## Timing
- Requests are sampled at edge k; the matching `push`/`pop`/`gnt_*` are high during cycle k+1.
- `fifo_count` changes at edge k, the same edge that raises the strobes.
- Latency from request to strobe is 1 cycle. A held request is served every cycle it remains eligible.
- A requester must drop its request one cycle after it sees its grant, or it will be granted again.
- `full` and `empty` are combinational from the registered `fifo_count`; they carry no extra latency.
- Flush drain takes `fifo_count + 1` edges from the first FLUSH edge to `flush_done`.

## Test plan
1. **Round-robin:** hold `req_push = 2'b11` for 4 cycles from reset, with `req_pop` at 0.
   - `gnt_push` sequence is 01, 10, 01, 10.
   - `fifo_count` steps 1 through 4.
2. **Overflow guard:** hold `req_push[0]` for 20 cycles, with `MAXCOUNT = 16`.
   - Exactly 16 `push` strobes are issued.
   - `full` rises with `fifo_count = 16`; `push` stays 0 afterwards.
3. **Push and pop at full:** at `fifo_count = 16`, assert `req_push[1]` and `req_pop` together for 3 cycles.
   - `push` and `pop` are both high each cycle.
   - `fifo_count` stays at 16.
4. **Underflow guard:** from empty, assert `req_pop` for 3 cycles.
   - No `pop` and no `gnt_pop`; `empty` stays 1.
   - Adding `req_push[0]` in the same cycle produces a push only, and `fifo_count` becomes 1.
5. **Flush from count 5:** pulse `flush_req` while `req_push = 2'b11`.
   - 5 consecutive `pop` strobes, with no `push` during FLUSH.
   - `flush_done` is high for one cycle when `fifo_count = 0`.
   - Pushes resume on the next cycle.
6. **Reset mid-flush:** assert `rst` asynchronously at `fifo_count = 3` during FLUSH.
   - All outputs return to their reset values before the next edge.
   - State is RUN; the next grant under `2'b11` goes to requester 0.

Source files
------------

// File: rtl/fifo_access_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_access_ctrl
//
// Access controller in front of a push/pop FIFO. Two producers share the
// single push slot under round-robin arbitration, and one consumer is served
// for pop. The controller keeps its own occupancy count to block overflow and
// underflow. It can also run a flush that pops the FIFO down to empty.
//
// Ports:
//   i_clk          clock, all state changes on posedge
//   i_rst          asynchronous active-high reset
//   i_req_push[1:0] level push request per producer (held until granted)
//   i_req_pop      level pop request from the consumer
//   i_flush_req    single-cycle pulse that starts a flush
//   o_push         registered push strobe to the FIFO
//   o_pop          registered pop strobe to the FIFO
//   o_gnt_push[1:0] registered one-hot push grant, coincides with o_push
//   o_gnt_pop      registered pop grant, low during flush
//   o_fifo_count   occupancy including the operations issued this cycle
//   o_full         o_fifo_count == MAXCOUNT
//   o_empty        o_fifo_count == 0
//   o_flush_done   one-cycle pulse when a flush completes
// ----------------------------------------------------------------------------
module fifo_access_ctrl #(
    parameter int MAXCOUNT = 16,
    parameter int CW       = $clog2(MAXCOUNT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_req_push,
    input  logic          i_req_pop,
    input  logic          i_flush_req,
    output logic          o_push,
    output logic          o_pop,
    output logic [1:0]    o_gnt_push,
    output logic          o_gnt_pop,
    output logic [CW-1:0] o_fifo_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_flush_done
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    logic          r_state;
    logic          r_last;      // index of the most recently granted producer
    logic [CW-1:0] r_count;

    logic          w_pop_ok;
    logic          w_push_ok;
    logic [1:0]    w_grant;

    // A push at full is legal only when a pop leaves on the same edge.
    assign w_pop_ok  = i_req_pop && (r_count != '0);
    assign w_push_ok = (|i_req_push) && ((r_count < CW'(MAXCOUNT)) || w_pop_ok);

    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_grant = 2'b00;
        if (w_push_ok) begin
            case (i_req_push)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                // Both requesting: the one that did not win last time wins.
                default: w_grant = r_last ? 2'b01 : 2'b10;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_last       <= 1'b1;
            r_count      <= '0;
            o_push       <= 1'b0;
            o_pop        <= 1'b0;
            o_gnt_push   <= 2'b00;
            o_gnt_pop    <= 1'b0;
            o_flush_done <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    o_push       <= w_push_ok;
                    o_pop        <= w_pop_ok;
                    o_gnt_push   <= w_grant;
                    o_gnt_pop    <= w_pop_ok;
                    o_flush_done <= 1'b0;
                    if (w_push_ok) begin
                        r_last <= w_grant[1];
                    end
                    if (w_push_ok && !w_pop_ok) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_push_ok && w_pop_ok) begin
                        r_count <= r_count - 1'b1;
                    end
                    // Operations decided on this edge still go out.
                    if (i_flush_req) begin
                        r_state <= ST_FLUSH;
                    end
                end
                default: begin
                    // Requests are held off; a new flush_req is ignored here.
                    o_push     <= 1'b0;
                    o_gnt_push <= 2'b00;
                    o_gnt_pop  <= 1'b0;
                    if (r_count != '0) begin
                        o_pop        <= 1'b1;
                        o_flush_done <= 1'b0;
                        r_count      <= r_count - 1'b1;
                    end else begin
                        o_pop        <= 1'b0;
                        o_flush_done <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign o_fifo_count = r_count;
    assign o_full       = (r_count == CW'(MAXCOUNT));
    assign o_empty      = (r_count == '0);

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_access_ctrl
//
// Directed bench for fifo_access_ctrl (MAXCOUNT = 16). Inputs change 1 ns
// after each rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_fifo_access_ctrl;

    localparam int MAXCOUNT = 16;
    localparam int CW       = $clog2(MAXCOUNT + 1);

    logic          clk;
    logic          rst;
    logic [1:0]    req_push;
    logic          req_pop;
    logic          flush_req;
    logic          push;
    logic          pop;
    logic [1:0]    gnt_push;
    logic          gnt_pop;
    logic [CW-1:0] fifo_count;
    logic          full;
    logic          empty;
    logic          flush_done;

    int n_pass;
    int n_total;
    int n_pushes;

    fifo_access_ctrl #(.MAXCOUNT(MAXCOUNT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_push   (req_push),
        .i_req_pop    (req_pop),
        .i_flush_req  (flush_req),
        .o_push       (push),
        .o_pop        (pop),
        .o_gnt_push   (gnt_push),
        .o_gnt_pop    (gnt_pop),
        .o_fifo_count (fifo_count),
        .o_full       (full),
        .o_empty      (empty),
        .o_flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".push"},       32'(push),       32'd0);
        check({tag, ".pop"},        32'(pop),        32'd0);
        check({tag, ".gnt_push"},   32'(gnt_push),   32'd0);
        check({tag, ".gnt_pop"},    32'(gnt_pop),    32'd0);
        check({tag, ".flush_done"}, 32'(flush_done), 32'd0);
        check({tag, ".count"},      32'(fifo_count), 32'd0);
        check({tag, ".empty"},      32'(empty),      32'd1);
        check({tag, ".full"},       32'(full),       32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        req_push  = 2'b00;
        req_pop   = 1'b0;
        flush_req = 1'b0;
        #12;
        check_reset_values("reset");
        rst = 1'b0;

        // ---- Round-robin: both producers held for 4 cycles ----
        req_push = 2'b11;
        tick(); check("rr1.gnt", 32'(gnt_push), 32'b01); check("rr1.cnt", 32'(fifo_count), 32'd1);
        tick(); check("rr2.gnt", 32'(gnt_push), 32'b10); check("rr2.cnt", 32'(fifo_count), 32'd2);
        tick(); check("rr3.gnt", 32'(gnt_push), 32'b01); check("rr3.cnt", 32'(fifo_count), 32'd3);
        tick(); check("rr4.gnt", 32'(gnt_push), 32'b10); check("rr4.cnt", 32'(fifo_count), 32'd4);
        check("rr4.push", 32'(push), 32'd1);
        req_push = 2'b00;
        tick(); check("rr_idle.push", 32'(push), 32'd0); check("rr_idle.cnt", 32'(fifo_count), 32'd4);

        // ---- Overflow guard: producer 0 held 20 cycles from empty ----
        do_reset();
        req_push = 2'b01;
        n_pushes = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (push) n_pushes++;
            if (i == 15) check("ovf.full_before", 32'(full), 32'd0);
            if (i == 16) begin
                check("ovf.full_at16", 32'(full), 32'd1);
                check("ovf.cnt_at16", 32'(fifo_count), 32'd16);
            end
        end
        check("ovf.num_pushes", 32'(n_pushes), 32'd16);
        check("ovf.push_after", 32'(push), 32'd0);
        check("ovf.cnt_after", 32'(fifo_count), 32'd16);

        // ---- Push and pop together at full ----
        req_push = 2'b10;
        req_pop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pf.push", 32'(push), 32'd1);
            check("pf.pop", 32'(pop), 32'd1);
            check("pf.gnt_push", 32'(gnt_push), 32'b10);
            check("pf.gnt_pop", 32'(gnt_pop), 32'd1);
            check("pf.cnt", 32'(fifo_count), 32'd16);
        end
        req_push = 2'b00;
        req_pop  = 1'b0;

        // ---- Flush from full with no requests ----
        flush_req = 1'b1;
        tick(); flush_req = 1'b0;
        check("f16.enter_pop", 32'(pop), 32'd0);
        check("f16.enter_cnt", 32'(fifo_count), 32'd16);
        for (int i = 15; i >= 0; i--) begin
            tick();
            check("f16.pop", 32'(pop), 32'd1);
            check("f16.cnt", 32'(fifo_count), 32'(i));
        end
        tick();
        check("f16.done", 32'(flush_done), 32'd1);
        check("f16.pop_off", 32'(pop), 32'd0);
        tick();
        check("f16.done_pulse", 32'(flush_done), 32'd0);

        // ---- Underflow guard ----
        req_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("uf.pop", 32'(pop), 32'd0);
            check("uf.gnt_pop", 32'(gnt_pop), 32'd0);
            check("uf.empty", 32'(empty), 32'd1);
        end
        req_push = 2'b01;
        tick();
        check("uf.push", 32'(push), 32'd1);
        check("uf.pop2", 32'(pop), 32'd0);
        check("uf.cnt", 32'(fifo_count), 32'd1);
        req_pop = 1'b0;

        // ---- Flush with both producers requesting ----
        // Last grant went to producer 0, so producer 1 wins next.
        req_push = 2'b11;
        tick(); check("fl.g1", 32'(gnt_push), 32'b10);
        tick(); check("fl.g2", 32'(gnt_push), 32'b01);
        tick(); check("fl.g3", 32'(gnt_push), 32'b10); check("fl.cnt4", 32'(fifo_count), 32'd4);
        flush_req = 1'b1;
        tick(); flush_req = 1'b0;
        check("fl.entry_push", 32'(push), 32'd1);
        check("fl.entry_gnt", 32'(gnt_push), 32'b01);
        check("fl.cnt5", 32'(fifo_count), 32'd5);
        for (int i = 4; i >= 0; i--) begin
            tick();
            check("fl.pop", 32'(pop), 32'd1);
            check("fl.no_push", 32'(push), 32'd0);
            check("fl.no_gnt", 32'(gnt_push), 32'd0);
            check("fl.cnt", 32'(fifo_count), 32'(i));
        end
        tick();
        check("fl.done", 32'(flush_done), 32'd1);
        check("fl.done_push", 32'(push), 32'd0);
        check("fl.done_cnt", 32'(fifo_count), 32'd0);
        tick();
        check("fl.resume_push", 32'(push), 32'd1);
        check("fl.resume_gnt", 32'(gnt_push), 32'b10);
        check("fl.done_low", 32'(flush_done), 32'd0);

        // ---- Reset in the middle of a flush at count 3 ----
        tick();
        flush_req = 1'b1;
        tick(); flush_req = 1'b0;
        req_push = 2'b00;
        check("rm.cnt3", 32'(fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rm");
        rst = 1'b0;
        req_push = 2'b11;
        tick();
        check("rm.gnt_first", 32'(gnt_push), 32'b01);
        check("rm.push_run", 32'(push), 32'd1);
        check("rm.cnt1", 32'(fifo_count), 32'd1);

        // ---- Flush from empty; second flush_req inside FLUSH ignored ----
        req_push = 2'b00;
        req_pop  = 1'b1;
        tick(); check("fe.drain", 32'(fifo_count), 32'd0);
        req_pop   = 1'b0;
        flush_req = 1'b1;
        tick();
        check("fe.edge1_done", 32'(flush_done), 32'd0);
        check("fe.edge1_gntpop", 32'(gnt_pop), 32'd0);
        tick(); flush_req = 1'b0;
        check("fe.edge2_done", 32'(flush_done), 32'd1);
        tick();
        check("fe.edge3_done", 32'(flush_done), 32'd0);
        req_push = 2'b01;
        tick();
        check("fe.run_push", 32'(push), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
